// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single valid/ready memory port between instruction fetch and load/store.
// The winner's request is registered onto the bus and held until bus_ready or a timeout.
module mem_bus_arbiter #(
  parameter int DATA_W         = 64,
  parameter bit RR_MODE        = 1'b0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              if_valid_i,
  input  logic [DATA_W-1:0] if_addr_i,
  input  logic [1:0]        if_size_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_data_read_o,
  output logic [1:0]        if_resp_o,
  input  logic              mem_valid_i,
  input  logic              mem_we_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic [1:0]        mem_size_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [7:0]        mem_wmask_i,
  output logic              mem_ready_o,
  output logic [DATA_W-1:0] mem_data_read_o,
  output logic [1:0]        mem_resp_o,
  output logic              bus_valid_o,
  output logic              bus_we_o,
  output logic [DATA_W-1:0] bus_addr_o,
  output logic [1:0]        bus_size_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [7:0]        bus_wmask_o,
  input  logic              bus_ready_i,
  input  logic [DATA_W-1:0] bus_data_read_i,
  input  logic [1:0]        bus_resp_i,
  output logic [1:0]        arb_grant_o
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM} state_e;

  localparam bit         TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic                last_mem_q, last_mem_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                bus_we_q, bus_we_d;
  logic [DATA_W-1:0]   bus_addr_q, bus_addr_d;
  logic [1:0]          bus_size_q, bus_size_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [7:0]          bus_wmask_q, bus_wmask_d;

  logic                timeout_hit;
  logic                done;
  logic                grant_mem;
  logic [DATA_W-1:0]   rsp_data;
  logic [1:0]          rsp_code;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      cnt_q       <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_size_q  <= '0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      cnt_q       <= cnt_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_size_q  <= bus_size_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
    end
  end

  // A real bus_ready always beats a coincident timeout, so real data/resp win.
  always_comb begin
    state_d         = state_q;
    last_mem_d      = last_mem_q;
    cnt_d           = cnt_q;
    bus_we_d        = bus_we_q;
    bus_addr_d      = bus_addr_q;
    bus_size_d      = bus_size_q;
    bus_wdata_d     = bus_wdata_q;
    bus_wmask_d     = bus_wmask_q;
    if_ready_o      = 1'b0;
    if_data_read_o  = '0;
    if_resp_o       = 2'b00;
    mem_ready_o     = 1'b0;
    mem_data_read_o = '0;
    mem_resp_o      = 2'b00;
    timeout_hit     = TIMEOUT_EN && (cnt_q == TO_LAST) && !bus_ready_i;
    done            = bus_ready_i || timeout_hit;
    rsp_data        = bus_ready_i ? bus_data_read_i : '0;
    rsp_code        = bus_ready_i ? bus_resp_i : 2'b10;
    grant_mem       = (if_valid_i && mem_valid_i) ? (RR_MODE ? !last_mem_q : 1'b1)
                                                  : mem_valid_i;

    case (state_q)
      IDLE: begin
        if (if_valid_i || mem_valid_i) begin
          cnt_d = '0;
          if (grant_mem) begin
            state_d     = GNT_MEM;
            last_mem_d  = 1'b1;
            bus_we_d    = mem_we_i;
            bus_addr_d  = mem_addr_i;
            bus_size_d  = mem_size_i;
            bus_wdata_d = mem_wdata_i;
            bus_wmask_d = mem_wmask_i;
          end else begin
            state_d     = GNT_IF;
            last_mem_d  = 1'b0;
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr_i;
            bus_size_d  = if_size_i;
            bus_wdata_d = '0;
            bus_wmask_d = '0;
          end
        end
      end
      GNT_IF: begin
        cnt_d = cnt_q + 8'd1;
        if (done) begin
          state_d        = IDLE;
          if_ready_o     = 1'b1;
          if_data_read_o = rsp_data;
          if_resp_o      = rsp_code;
        end
      end
      GNT_MEM: begin
        cnt_d = cnt_q + 8'd1;
        if (done) begin
          state_d         = IDLE;
          mem_ready_o     = 1'b1;
          mem_data_read_o = rsp_data;
          mem_resp_o      = rsp_code;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_valid_o = (state_q != IDLE);
  assign arb_grant_o = {state_q == GNT_MEM, state_q == GNT_IF};
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_size_o  = bus_size_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_wmask_o = bus_wmask_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Drives a fixed-priority (timeout 4) and a round-robin (no timeout) arbiter with shared
// stimulus and compares both every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          ifValid, memValid, memWe, busReady;
  logic [DW-1:0] ifAddr, memAddr, memWdata, busDataRead;
  logic [1:0]    ifSize, memSize, busResp;
  logic [7:0]    memWmask;

  logic          ifReadyO[2], memReadyO[2], busValidO[2], busWeO[2];
  logic [DW-1:0] ifDataO[2], memDataO[2], busAddrO[2], busWdataO[2];
  logic [1:0]    ifRespO[2], memRespO[2], busSizeO[2], grantO[2];
  logic [7:0]    busWmaskO[2];

  int checks = 0;
  int passes = 0;

  // Reference model: owner 0=none, 1=fetch, 2=load/store; age counts grant cycles so far.
  int            owner[2];
  int            age[2];
  bit            lastMem[2];
  bit            finishNow[2];
  logic          capWe[2];
  logic [DW-1:0] capAddr[2], capWdata[2];
  logic [1:0]    capSize[2];
  logic [7:0]    capWmask[2];
  int            timeoutOf[2] = '{4, 0};
  bit            rrOf[2]      = '{1'b0, 1'b1};

  always #5 clock = ~clock;

  mem_bus_arbiter #(.DATA_W(DW), .RR_MODE(1'b0), .TIMEOUT_CYCLES(4)) dutFixed (
    .clock_i(clock), .reset_i(reset),
    .if_valid_i(ifValid), .if_addr_i(ifAddr), .if_size_i(ifSize),
    .if_ready_o(ifReadyO[0]), .if_data_read_o(ifDataO[0]), .if_resp_o(ifRespO[0]),
    .mem_valid_i(memValid), .mem_we_i(memWe), .mem_addr_i(memAddr), .mem_size_i(memSize),
    .mem_wdata_i(memWdata), .mem_wmask_i(memWmask),
    .mem_ready_o(memReadyO[0]), .mem_data_read_o(memDataO[0]), .mem_resp_o(memRespO[0]),
    .bus_valid_o(busValidO[0]), .bus_we_o(busWeO[0]), .bus_addr_o(busAddrO[0]),
    .bus_size_o(busSizeO[0]), .bus_wdata_o(busWdataO[0]), .bus_wmask_o(busWmaskO[0]),
    .bus_ready_i(busReady), .bus_data_read_i(busDataRead), .bus_resp_i(busResp),
    .arb_grant_o(grantO[0])
  );

  mem_bus_arbiter #(.DATA_W(DW), .RR_MODE(1'b1), .TIMEOUT_CYCLES(0)) dutRr (
    .clock_i(clock), .reset_i(reset),
    .if_valid_i(ifValid), .if_addr_i(ifAddr), .if_size_i(ifSize),
    .if_ready_o(ifReadyO[1]), .if_data_read_o(ifDataO[1]), .if_resp_o(ifRespO[1]),
    .mem_valid_i(memValid), .mem_we_i(memWe), .mem_addr_i(memAddr), .mem_size_i(memSize),
    .mem_wdata_i(memWdata), .mem_wmask_i(memWmask),
    .mem_ready_o(memReadyO[1]), .mem_data_read_o(memDataO[1]), .mem_resp_o(memRespO[1]),
    .bus_valid_o(busValidO[1]), .bus_we_o(busWeO[1]), .bus_addr_o(busAddrO[1]),
    .bus_size_o(busSizeO[1]), .bus_wdata_o(busWdataO[1]), .bus_wmask_o(busWmaskO[1]),
    .bus_ready_i(busReady), .bus_data_read_i(busDataRead), .bus_resp_i(busResp),
    .arb_grant_o(grantO[1])
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = 0; age[k] = 0; lastMem[k] = 1'b0;
      capWe[k] = 1'b0; capAddr[k] = '0; capWdata[k] = '0; capSize[k] = '0; capWmask[k] = '0;
    end
  endtask

  task automatic modelAdvance();
    for (int k = 0; k < 2; k++) begin
      if (owner[k] != 0) begin
        if (finishNow[k]) owner[k] = 0;
        else age[k]++;
      end else if (ifValid || memValid) begin
        bit pickMem;
        if (ifValid && memValid) pickMem = rrOf[k] ? !lastMem[k] : 1'b1;
        else pickMem = memValid;
        owner[k] = pickMem ? 2 : 1;
        lastMem[k] = pickMem;
        age[k] = 0;
        capAddr[k]  = pickMem ? memAddr : ifAddr;
        capSize[k]  = pickMem ? memSize : ifSize;
        capWe[k]    = pickMem ? memWe : 1'b0;
        capWmask[k] = pickMem ? memWmask : 8'h00;
        capWdata[k] = memWdata;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ifv, input logic [DW-1:0] ifa,
                               input logic [1:0] ifs, input logic memv, input logic mwe,
                               input logic [DW-1:0] ma, input logic [1:0] ms,
                               input logic [DW-1:0] wd, input logic [7:0] wm, input logic br,
                               input logic [DW-1:0] bd, input logic [1:0] bresp);
    @(negedge clock);
    reset = rst; ifValid = ifv; ifAddr = ifa; ifSize = ifs;
    memValid = memv; memWe = mwe; memAddr = ma; memSize = ms; memWdata = wd; memWmask = wm;
    busReady = br; busDataRead = bd; busResp = bresp;
    if (rst) modelReset();
    #1;
    for (int k = 0; k < 2; k++) begin
      bit fin;
      bit expIf, expMem;
      fin = (owner[k] != 0) && (br || (timeoutOf[k] != 0 && age[k] == timeoutOf[k] - 1));
      finishNow[k] = fin;
      expIf  = fin && owner[k] == 1;
      expMem = fin && owner[k] == 2;
      checkOutput($sformatf("ifReady%0d", k), DW'(ifReadyO[k]), DW'(expIf));
      checkOutput($sformatf("ifData%0d", k), ifDataO[k], (expIf && br) ? bd : '0);
      checkOutput($sformatf("ifResp%0d", k), DW'(ifRespO[k]), DW'(expIf ? (br ? bresp : 2'b10) : 2'b00));
      checkOutput($sformatf("memReady%0d", k), DW'(memReadyO[k]), DW'(expMem));
      checkOutput($sformatf("memData%0d", k), memDataO[k], (expMem && br) ? bd : '0);
      checkOutput($sformatf("memResp%0d", k), DW'(memRespO[k]), DW'(expMem ? (br ? bresp : 2'b10) : 2'b00));
      checkOutput($sformatf("busValid%0d", k), DW'(busValidO[k]), DW'(owner[k] != 0));
      checkOutput($sformatf("grant%0d", k), DW'(grantO[k]),
                  DW'(owner[k] == 1 ? 2'b01 : owner[k] == 2 ? 2'b10 : 2'b00));
      if (owner[k] != 0) begin
        checkOutput($sformatf("busAddr%0d", k), busAddrO[k], capAddr[k]);
        checkOutput($sformatf("busSize%0d", k), DW'(busSizeO[k]), DW'(capSize[k]));
        checkOutput($sformatf("busWe%0d", k), DW'(busWeO[k]), DW'(capWe[k]));
        checkOutput($sformatf("busWmask%0d", k), DW'(busWmaskO[k]), DW'(capWmask[k]));
        if (owner[k] == 2) checkOutput($sformatf("busWdata%0d", k), busWdataO[k], capWdata[k]);
      end
    end
    @(posedge clock);
    if (!rst) modelAdvance();
  endtask

  initial begin
    logic ifvR, memvR, rstR;
    reset = 1'b1; ifValid = 1'b0; memValid = 1'b0; busReady = 1'b0;
    ifAddr = '0; ifSize = '0; memWe = 1'b0; memAddr = '0; memSize = '0;
    memWdata = '0; memWmask = '0; busDataRead = '0; busResp = '0;
    modelReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single fetch completing on its third grant cycle with data 0x13.
    applyStimulus(0, 1, 64'h8000_0000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 64'h8000_0000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 64'h8000_0000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 64'h8000_0000, 2, 0, 0, 0, 0, 0, 1, 64'h13, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Contention held across several transactions, then a hung bus.
    for (int n = 0; n < 14; n++)
      applyStimulus(0, 1, 64'h100 + 64'(n), 3, 1, 0, 64'h200 + 64'(n), 1, 0, 0,
                    (n % 3) == 2, 64'(n), 2'b11);
    for (int n = 0; n < 6; n++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 64'h55, 0);

    // Store with stable fields; inputs wander after the grant edge.
    applyStimulus(0, 0, 0, 0, 1, 1, 64'h40, 2, 64'hDEAD_BEEF, 8'h0F, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 64'h99, 0, 64'h1234, 8'hF0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 64'h77, 1, 64'h5678, 8'hAA, 1, 64'h1, 2'b10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a load/store grant.
    applyStimulus(0, 0, 0, 0, 1, 0, 64'h300, 3, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 64'h300, 3, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 64'h300, 3, 0, 0, 1, 64'h9, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h9, 0);

    ifvR = 1'b0; memvR = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) ifvR = ~ifvR;
      if ($urandom_range(0, 3) == 0) memvR = ~memvR;
      rstR = ($urandom_range(0, 149) == 0);
      applyStimulus(rstR, ifvR, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                    memvR, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    2'($urandom_range(0, 3)), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 2) == 0), {$urandom, $urandom},
                    2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
